riscv_test_monitor: RTL

- Synthesizable, parametrised end-of-test monitor for riscv-tests runs on the core.
- Watches the core PC and gp (x3); decides pass, fail or timeout; reports the failing test number and the cycles used.
- Instantiated next to the core in every rv32ui-p-* bench, replacing per-bench hard-coded checks.
- Can be kept in FPGA builds to drive status LEDs.

---
 rtl/riscv_test_monitor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor for riscv-tests: watches PC and gp (x3) and reports pass/fail/timeout.
// Optional tohost write detection is enabled with `define MONITOR_TOHOST_EN.
module riscv_test_monitor #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] HALT_PC       = XLEN'(32'h44),
  parameter int              SETTLE_CYCLES = 2,
  parameter int              TIMEOUT_TICKS = 5000,
  parameter int              CNT_W         = 16
`ifdef MONITOR_TOHOST_EN
  ,
  parameter logic [31:0]     TOHOST_ADDR   = 32'h1000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  gp_i,
`ifdef MONITOR_TOHOST_EN
  input  logic             tohost_we,
  input  logic [31:0]      tohost_addr,
  input  logic [XLEN-1:0]  tohost_data,
`endif
  output logic             busy,
  output logic             done,
  output logic             passed,
  output logic             failed,
  output logic             timed_out,
  output logic [XLEN-2:0]  fail_test_num,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t           r_state, w_state_d;
  logic [3:0]       r_match, w_match_d, w_match_inc;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [XLEN-2:0]  r_ftn, w_ftn_d;
  logic             r_busy, r_done, r_pass, r_fail, r_to;
  logic             w_busy_d, w_done_d, w_pass_d, w_fail_d, w_to_d;
  logic             w_tohost_hit, w_tohost_pass;
  logic [XLEN-2:0]  w_tohost_num;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef MONITOR_TOHOST_EN
  assign w_tohost_hit  = tohost_we && (tohost_addr == TOHOST_ADDR) && tohost_data[0];
  assign w_tohost_pass = (tohost_data == XLEN'(1));
  assign w_tohost_num  = tohost_data[XLEN-1:1];
`else
  assign w_tohost_hit  = 1'b0;
  assign w_tohost_pass = 1'b0;
  assign w_tohost_num  = '0;
`endif

  // A PC that drops off HALT_PC restarts the settle count from zero.
  assign w_match_inc = (pc_i == HALT_PC) ? r_match + 4'd1 : 4'd0;

  always_comb begin
    w_state_d = r_state;
    w_match_d = r_match;
    w_cnt_d   = r_cnt;
    w_ftn_d   = r_ftn;
    w_busy_d  = r_busy;
    w_done_d  = r_done;
    w_pass_d  = r_pass;
    w_fail_d  = r_fail;
    w_to_d    = r_to;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_d = S_RUN;
          w_match_d = '0;
          w_cnt_d   = '0;
          w_ftn_d   = '0;
          w_busy_d  = 1'b1;
          w_done_d  = 1'b0;
          w_pass_d  = 1'b0;
          w_fail_d  = 1'b0;
          w_to_d    = 1'b0;
        end
      end
      S_RUN: begin
        w_match_d = w_match_inc;
        w_cnt_d   = sat_inc(r_cnt);
        // Priority: tohost write, then settled PC match, then timeout.
        if (w_tohost_hit) begin
          w_state_d = S_DONE;
          w_busy_d  = 1'b0;
          w_done_d  = 1'b1;
          w_pass_d  = w_tohost_pass;
          w_fail_d  = !w_tohost_pass;
          if (!w_tohost_pass) w_ftn_d = w_tohost_num;
        end else if (w_match_inc == 4'(SETTLE_CYCLES)) begin
          w_state_d = S_CHECK;
        end else if (r_cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
          w_state_d = S_DONE;
          w_cnt_d   = r_cnt;
          w_busy_d  = 1'b0;
          w_done_d  = 1'b1;
          w_to_d    = 1'b1;
        end
      end
      S_CHECK: begin
        w_state_d = S_DONE;
        w_busy_d  = 1'b0;
        w_done_d  = 1'b1;
        if (gp_i == XLEN'(1)) begin
          w_pass_d = 1'b1;
        end else begin
          w_fail_d = 1'b1;
          w_ftn_d  = gp_i[XLEN-1:1];
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_match <= '0;
      r_cnt   <= '0;
      r_ftn   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_match <= w_match_d;
      r_cnt   <= w_cnt_d;
      r_ftn   <= w_ftn_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_pass  <= w_pass_d;
      r_fail  <= w_fail_d;
      r_to    <= w_to_d;
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign passed        = r_pass;
  assign failed        = r_fail;
  assign timed_out     = r_to;
  assign fail_test_num = r_ftn;
  assign cycle_count   = r_cnt;

endmodule
